// File: rtl/sobel_edge_kernel.sv
// Sobel |Gx|+|Gy| edge kernel on a 3x3 window stream, with optional binary threshold.
// Latency: fixed 3 clocks from in_valid to out_valid, one result per clock.
// Backpressure: none; the pipe advances every clock and bubbles pass through as out_valid=0.
//
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   in_valid                - window taps and coordinates valid this cycle
//   window0..window8        - 3x3 taps, row-major (0..2 top, 3..5 middle, 6..8 bottom)
//   AH, AV                  - coordinate of the window's newest pixel
//   threshold, binary_mode  - edge threshold and output select, applied at the last stage
//   out_pixel, out_edge     - magnitude (or binary map) and edge flag, zero when not valid
//   out_AH, out_AV          - window-centre coordinate aligned with out_pixel
//   out_valid               - output valid
module sobel_edge_kernel #(
  parameter int WORD_SIZE = 16,
  parameter int PIX_BITS  = 8,
  parameter int ROW_SIZE  = 180,
  parameter int COL_SIZE  = 120,
  parameter int SHIFT     = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] window0,
  input  logic [WORD_SIZE-1:0] window1,
  input  logic [WORD_SIZE-1:0] window2,
  input  logic [WORD_SIZE-1:0] window3,
  input  logic [WORD_SIZE-1:0] window4,
  input  logic [WORD_SIZE-1:0] window5,
  input  logic [WORD_SIZE-1:0] window6,
  input  logic [WORD_SIZE-1:0] window7,
  input  logic [WORD_SIZE-1:0] window8,
  input  logic [9:0]           AH,
  input  logic [8:0]           AV,
  input  logic [PIX_BITS-1:0]  threshold,
  input  logic                 binary_mode,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_edge,
  output logic [9:0]           out_AH,
  output logic [8:0]           out_AV,
  output logic                 out_valid
);

  // Gradient width: +-4*(2^PIX_BITS-1) needs PIX_BITS+3 bits two's complement.
  localparam int GW = PIX_BITS + 3;
  // Absolute gradient width: 4*(2^PIX_BITS-1) fits in PIX_BITS+2 bits unsigned.
  localparam int AW = PIX_BITS + 2;

  localparam logic [9:0]          LP_H_LAST  = 10'(ROW_SIZE - 1);
  localparam logic [8:0]          LP_V_LAST  = 9'(COL_SIZE - 1);
  localparam logic [PIX_BITS-1:0] LP_PIX_MAX = '1;
  localparam logic [GW-1:0]       LP_ONE     = GW'(1);

  // Zero-extend a luminance sample to gradient width.
  function automatic logic [GW-1:0] ext(input logic [PIX_BITS-1:0] v);
    return {3'b000, v};
  endfunction

  // Magnitude of a two's complement gradient. Since |G| <= 4*(2^PIX_BITS-1),
  // the negation never overflows and the top bit of the result is always 0.
  function automatic logic [AW-1:0] abs_grad(input logic [GW-1:0] v);
    logic [GW-1:0] t;
    t = v[GW-1] ? (~v + LP_ONE) : v;
    return t[AW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1 inputs: luminance extraction, gradients, centre coordinate, border
  // ---------------------------------------------------------------------------
  logic [PIX_BITS-1:0] w_p [9];

  assign w_p[0] = window0[PIX_BITS-1:0];
  assign w_p[1] = window1[PIX_BITS-1:0];
  assign w_p[2] = window2[PIX_BITS-1:0];
  assign w_p[3] = window3[PIX_BITS-1:0];
  assign w_p[4] = window4[PIX_BITS-1:0];
  assign w_p[5] = window5[PIX_BITS-1:0];
  assign w_p[6] = window6[PIX_BITS-1:0];
  assign w_p[7] = window7[PIX_BITS-1:0];
  assign w_p[8] = window8[PIX_BITS-1:0];

  // Upper tap bits carry no luminance; the centre tap never enters the Sobel sum.
  logic w_unused_taps;
  assign w_unused_taps = ^{window0[WORD_SIZE-1:PIX_BITS], window1[WORD_SIZE-1:PIX_BITS],
                           window2[WORD_SIZE-1:PIX_BITS], window3[WORD_SIZE-1:PIX_BITS],
                           window4,
                           window5[WORD_SIZE-1:PIX_BITS], window6[WORD_SIZE-1:PIX_BITS],
                           window7[WORD_SIZE-1:PIX_BITS], window8[WORD_SIZE-1:PIX_BITS],
                           w_p[4]};

  logic [GW-1:0] w_gx_pos;
  logic [GW-1:0] w_gx_neg;
  logic [GW-1:0] w_gy_pos;
  logic [GW-1:0] w_gy_neg;
  logic [GW-1:0] w_gx;
  logic [GW-1:0] w_gy;

  // Each partial sum is at most 4*(2^PIX_BITS-1), so unsigned GW-bit sums are
  // exact and the GW-bit difference is the correct two's complement gradient.
  assign w_gx_pos = ext(w_p[2]) + (ext(w_p[5]) << 1) + ext(w_p[8]);
  assign w_gx_neg = ext(w_p[0]) + (ext(w_p[3]) << 1) + ext(w_p[6]);
  assign w_gy_pos = ext(w_p[6]) + (ext(w_p[7]) << 1) + ext(w_p[8]);
  assign w_gy_neg = ext(w_p[0]) + (ext(w_p[1]) << 1) + ext(w_p[2]);
  assign w_gx     = w_gx_pos - w_gx_neg;
  assign w_gy     = w_gy_pos - w_gy_neg;

  // The window centre is one pixel behind (left of / above) the newest pixel;
  // coordinate 0 means the centre wrapped to the last column/line.
  logic [9:0] w_ch;
  logic [8:0] w_cv;
  logic       w_border;

  assign w_ch     = (AH == 10'd0) ? LP_H_LAST : (AH - 10'd1);
  assign w_cv     = (AV == 9'd0)  ? LP_V_LAST : (AV - 9'd1);
  assign w_border = (w_ch == 10'd0) || (w_ch == LP_H_LAST) ||
                    (w_cv == 9'd0)  || (w_cv == LP_V_LAST);

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic          r1_vld;
  logic [GW-1:0] r1_gx;
  logic [GW-1:0] r1_gy;
  logic [9:0]    r1_ch;
  logic [8:0]    r1_cv;
  logic          r1_border;

  // Data is zeroed on bubbles so nothing stale can travel down the pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r1_vld    <= 1'b0;
      r1_gx     <= '0;
      r1_gy     <= '0;
      r1_ch     <= '0;
      r1_cv     <= '0;
      r1_border <= 1'b0;
    end else begin
      r1_vld <= in_valid;
      if (in_valid) begin
        r1_gx     <= w_gx;
        r1_gy     <= w_gy;
        r1_ch     <= w_ch;
        r1_cv     <= w_cv;
        r1_border <= w_border;
      end else begin
        r1_gx     <= '0;
        r1_gy     <= '0;
        r1_ch     <= '0;
        r1_cv     <= '0;
        r1_border <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: absolute values
  // ---------------------------------------------------------------------------
  logic          r2_vld;
  logic [AW-1:0] r2_ax;
  logic [AW-1:0] r2_ay;
  logic [9:0]    r2_ch;
  logic [8:0]    r2_cv;
  logic          r2_border;

  always_ff @(posedge clock) begin
    if (reset) begin
      r2_vld    <= 1'b0;
      r2_ax     <= '0;
      r2_ay     <= '0;
      r2_ch     <= '0;
      r2_cv     <= '0;
      r2_border <= 1'b0;
    end else begin
      r2_vld    <= r1_vld;
      r2_ax     <= abs_grad(r1_gx);
      r2_ay     <= abs_grad(r1_gy);
      r2_ch     <= r1_ch;
      r2_cv     <= r1_cv;
      r2_border <= r1_border;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: sum, scale, saturate, threshold, output select
  // ---------------------------------------------------------------------------
  logic [GW-1:0]       w_sum;
  logic [GW-1:0]       w_raw;
  logic [PIX_BITS-1:0] w_sat;
  logic [PIX_BITS-1:0] w_mag;
  logic                w_edge;
  logic [PIX_BITS-1:0] w_pix;

  assign w_sum = {1'b0, r2_ax} + {1'b0, r2_ay};
  assign w_raw = w_sum >> SHIFT;
  assign w_sat = (|w_raw[GW-1:PIX_BITS]) ? LP_PIX_MAX : w_raw[PIX_BITS-1:0];

  // Border pixels are forced to "no edge" even when threshold is 0.
  assign w_mag  = r2_border ? '0 : w_sat;
  assign w_edge = !r2_border && (w_sat >= threshold);
  assign w_pix  = binary_mode ? (w_edge ? LP_PIX_MAX : '0) : w_mag;

  logic [WORD_SIZE-1:0] r_out_pixel;
  logic                 r_out_edge;
  logic [9:0]           r_out_ah;
  logic [8:0]           r_out_av;
  logic                 r_out_valid;

  // Gated on valid: with threshold 0 a zeroed bubble would otherwise look like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_edge  <= 1'b0;
      r_out_ah    <= '0;
      r_out_av    <= '0;
    end else begin
      r_out_valid <= r2_vld;
      if (r2_vld) begin
        r_out_pixel <= {{(WORD_SIZE-PIX_BITS){1'b0}}, w_pix};
        r_out_edge  <= w_edge;
        r_out_ah    <= r2_ch;
        r_out_av    <= r2_cv;
      end else begin
        r_out_pixel <= '0;
        r_out_edge  <= 1'b0;
        r_out_ah    <= '0;
        r_out_av    <= '0;
      end
    end
  end

  assign out_pixel = r_out_pixel;
  assign out_edge  = r_out_edge;
  assign out_AH    = r_out_ah;
  assign out_AV    = r_out_av;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_sobel_edge_kernel.sv
// Self-checking bench for sobel_edge_kernel: two instances (SHIFT=0 and SHIFT=2)
// share one stimulus stream; a reference model predicts every output cycle and
// directed vectors pin the model with hand-computed literals.
module tb_sobel_edge_kernel;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid;
  logic [15:0] win [9];
  logic [9:0]  AH;
  logic [8:0]  AV;
  logic [7:0]  threshold;
  logic        binary_mode;

  logic [15:0] a_pixel, b_pixel;
  logic        a_edge, b_edge;
  logic [9:0]  a_ah, b_ah;
  logic [8:0]  a_av, b_av;
  logic        a_valid, b_valid;

  sobel_edge_kernel #(.SHIFT(0)) u_dut_s0 (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .window0(win[0]), .window1(win[1]), .window2(win[2]),
    .window3(win[3]), .window4(win[4]), .window5(win[5]),
    .window6(win[6]), .window7(win[7]), .window8(win[8]),
    .AH(AH), .AV(AV), .threshold(threshold), .binary_mode(binary_mode),
    .out_pixel(a_pixel), .out_edge(a_edge), .out_AH(a_ah), .out_AV(a_av),
    .out_valid(a_valid)
  );

  sobel_edge_kernel #(.SHIFT(2)) u_dut_s2 (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .window0(win[0]), .window1(win[1]), .window2(win[2]),
    .window3(win[3]), .window4(win[4]), .window5(win[5]),
    .window6(win[6]), .window7(win[7]), .window8(win[8]),
    .AH(AH), .AV(AV), .threshold(threshold), .binary_mode(binary_mode),
    .out_pixel(b_pixel), .out_edge(b_edge), .out_AH(b_ah), .out_AV(b_av),
    .out_valid(b_valid)
  );

  int checks   = 0;
  int failures = 0;
  bit en       = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Saturated magnitude of the window from plain integer Sobel arithmetic.
  function automatic int sobel_mag(input logic [15:0] t [9], input int sh);
    int p [9];
    int gx, gy, m;
    for (int i = 0; i < 9; i++) p[i] = int'(t[i][7:0]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = (gx + gy) >> sh;
    if (m > 255) m = 255;
    return m;
  endfunction

  // Model: history of the last four clock edges. The output seen after edge k
  // comes from the input sampled at edge k-2, provided no reset was sampled at
  // edges k-2..k, and uses threshold/binary_mode as sampled at edge k.
  bit h_rst [4];
  bit h_vld [4];
  bit h_bor [4];
  int h_ch [4], h_cv [4], h_m0 [4], h_m2 [4];

  bit e_vld;
  int e_pix0, e_edge0, e_pix2, e_edge2, e_ah, e_av;

  initial begin
    int k, cur, old, mid, ch, cv;
    for (int i = 0; i < 4; i++) begin
      h_rst[i] = 1'b1;
      h_vld[i] = 1'b0;
    end
    k = 0;
    forever begin
      @(posedge clock);
      k++;
      cur = k % 4;
      mid = (k + 3) % 4;
      old = (k + 2) % 4;
      ch = (AH == 0) ? 179 : int'(AH) - 1;
      cv = (AV == 0) ? 119 : int'(AV) - 1;
      h_rst[cur] = reset;
      h_vld[cur] = in_valid;
      h_ch[cur]  = ch;
      h_cv[cur]  = cv;
      h_bor[cur] = (ch == 0) || (ch == 179) || (cv == 0) || (cv == 119);
      h_m0[cur]  = sobel_mag(win, 0);
      h_m2[cur]  = sobel_mag(win, 2);

      e_vld   = h_vld[old] && !h_rst[old] && !h_rst[mid] && !h_rst[cur];
      e_ah    = h_ch[old];
      e_av    = h_cv[old];
      e_edge0 = (!h_bor[old] && h_m0[old] >= int'(threshold)) ? 1 : 0;
      e_edge2 = (!h_bor[old] && h_m2[old] >= int'(threshold)) ? 1 : 0;
      e_pix0  = h_bor[old] ? 0 : h_m0[old];
      e_pix2  = h_bor[old] ? 0 : h_m2[old];
      if (binary_mode) begin
        e_pix0 = e_edge0 ? 255 : 0;
        e_pix2 = e_edge2 ? 255 : 0;
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (en) begin
        chk("m_valid_s0", int'(a_valid), int'(e_vld));
        chk("m_valid_s2", int'(b_valid), int'(e_vld));
        if (e_vld) begin
          chk("m_pixel_s0", int'(a_pixel), e_pix0);
          chk("m_edge_s0",  int'(a_edge),  e_edge0);
          chk("m_ah_s0",    int'(a_ah),    e_ah);
          chk("m_av_s0",    int'(a_av),    e_av);
          chk("m_pixel_s2", int'(b_pixel), e_pix2);
          chk("m_edge_s2",  int'(b_edge),  e_edge2);
          chk("m_ah_s2",    int'(b_ah),    e_ah);
          chk("m_av_s2",    int'(b_av),    e_av);
        end
      end
    end
  end

  // Column values left/middle/right for every row.
  task automatic set_cols(input int l, input int m, input int r);
    for (int row = 0; row < 3; row++) begin
      win[3*row]   = 16'(l);
      win[3*row+1] = 16'(m);
      win[3*row+2] = 16'(r);
    end
  endtask

  // Row values top/middle/bottom for every column.
  task automatic set_rows(input int t, input int m, input int b);
    for (int c = 0; c < 3; c++) begin
      win[c]   = 16'(t);
      win[3+c] = 16'(m);
      win[6+c] = 16'(b);
    end
  endtask

  // Called at a negedge; returns three negedges later, when the result is visible.
  task automatic pulse(input int ah, input int av);
    in_valid = 1'b1;
    AH = 10'(ah);
    AV = 9'(av);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    int pv [4];
    reset = 1'b1;
    in_valid = 1'b0;
    set_cols(0, 0, 0);
    AH = '0;
    AV = '0;
    threshold = '0;
    binary_mode = 1'b0;
    repeat (3) @(negedge clock);

    chk("rst_valid", int'(a_valid), 0);
    chk("rst_pixel", int'(a_pixel), 0);
    chk("rst_edge",  int'(a_edge),  0);
    chk("rst_ah",    int'(a_ah),    0);
    chk("rst_av",    int'(b_av),    0);
    reset = 1'b0;
    en = 1'b1;
    @(negedge clock);

    // Flat field
    set_cols(16'h0040, 16'h0040, 16'h0040);
    threshold = 8'd1;
    pulse(10, 10);
    chk("flat_valid", int'(a_valid), 1);
    chk("flat_pixel", int'(a_pixel), 0);
    chk("flat_edge",  int'(a_edge),  0);
    chk("flat_ah",    int'(a_ah),    9);
    chk("flat_av",    int'(a_av),    9);
    @(negedge clock);

    // Vertical step: Gx=400, Gy=0
    set_cols(0, 100, 100);
    threshold = 8'd200;
    pulse(20, 20);
    chk("vstep_pixel_s0", int'(a_pixel), 255);
    chk("vstep_edge_s0",  int'(a_edge),  1);
    chk("vstep_ah",       int'(a_ah),    19);
    chk("vstep_pixel_s2", int'(b_pixel), 100);
    chk("vstep_edge_s2",  int'(b_edge),  0);
    @(negedge clock);

    // Negative horizontal step: Gy=-800, binary output, equality is an edge
    set_rows(200, 0, 0);
    threshold = 8'd255;
    binary_mode = 1'b1;
    pulse(30, 30);
    chk("hstep_pixel_s0", int'(a_pixel), 255);
    chk("hstep_edge_s0",  int'(a_edge),  1);
    chk("hstep_pixel_s2", int'(b_pixel), 0);
    chk("hstep_edge_s2",  int'(b_edge),  0);
    @(negedge clock);

    // Borders
    set_cols(0, 100, 100);
    threshold = 8'd200;
    binary_mode = 1'b0;
    pulse(1, 20);
    chk("bor_l_valid", int'(a_valid), 1);
    chk("bor_l_pixel", int'(a_pixel), 0);
    chk("bor_l_edge",  int'(a_edge),  0);
    chk("bor_l_ah",    int'(a_ah),    0);
    @(negedge clock);
    pulse(0, 20);
    chk("bor_r_pixel", int'(a_pixel), 0);
    chk("bor_r_edge",  int'(a_edge),  0);
    chk("bor_r_ah",    int'(a_ah),    179);
    @(negedge clock);
    pulse(20, 1);
    chk("bor_t_pixel", int'(a_pixel), 0);
    chk("bor_t_edge",  int'(a_edge),  0);
    chk("bor_t_ah",    int'(a_ah),    19);
    chk("bor_t_av",    int'(a_av),    0);
    @(negedge clock);

    // Throughput with a bubble
    pv = '{1, 1, 0, 1};
    set_cols(16'h0040, 16'h0040, 16'h0040);
    AV = 9'd10;
    for (int i = 0; i < 7; i++) begin
      if (i >= 3) begin
        chk("thru_valid", int'(a_valid), pv[i-3]);
        if (pv[i-3] == 1) chk("thru_ah", int'(a_ah), 4 + (i - 3));
      end
      if (i < 4) begin
        in_valid = pv[i][0];
        AH = 10'(5 + i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
    end

    // Reset mid-pipe
    set_cols(0, 100, 100);
    in_valid = 1'b1;
    AH = 10'd40;
    AV = 9'd40;
    @(negedge clock);
    AH = 10'd41;
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_valid_s0", int'(a_valid), 0);
      chk("midrst_valid_s2", int'(b_valid), 0);
      chk("midrst_pixel",    int'(a_pixel), 0);
      chk("midrst_ah",       int'(a_ah),    0);
      @(negedge clock);
    end

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 2000; n++) begin
      int mode, base, lvl;
      reset       = ($urandom_range(0, 99) == 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      threshold   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      binary_mode = $urandom_range(0, 1) == 1;
      AH = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1)) : 10'($urandom_range(0, 179));
      AV = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 1))  : 9'($urandom_range(0, 119));
      mode = $urandom_range(0, 2);
      base = $urandom_range(0, 255);
      lvl  = $urandom_range(0, 255);
      for (int i = 0; i < 9; i++) begin
        win[i] = 16'($urandom);
        case (mode)
          0:       win[i][7:0] = 8'($urandom_range(0, 255));
          1:       win[i][7:0] = ((i % 3) == 0) ? 8'(base) : 8'(lvl);
          default: win[i][7:0] = 8'((base + $urandom_range(0, 15)) % 256);
        endcase
      end
      @(negedge clock);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_edge_kernel.md
Name: sobel_edge_kernel

Overview:
- Consumer end of the 3x3 window stream.
- Takes the nine window taps plus the raster coordinates from the upstream window generator and computes the Sobel gradient magnitude |Gx|+|Gy| of the window centre.
- Optionally thresholds the result into a binary edge map.
- Produces one output pixel per clock, with aligned coordinates and a valid flag, for the VGA pixel path.

Parameters:
- WORD_SIZE, 16, width of each window tap and of the output pixel word.
- PIX_BITS, 8, number of low tap bits used as luminance (tap[PIX_BITS-1:0], unsigned).
- ROW_SIZE, 180, active pixels per line; used for horizontal border detection.
- COL_SIZE, 120, active lines per frame; used for vertical border detection.
- SHIFT, 0, right-shift applied to the raw magnitude before saturation.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  taps/coords valid this cycle.
- window0..window8  in  WORD_SIZE each  3x3 taps, row-major.
  - window0..2: top row, window3..5: middle row, window6..8: bottom row.
  - Within each row, left to right.
- AH  in  10  horizontal coordinate associated with this window's newest pixel.
- AV  in  9  vertical coordinate associated with this window's newest pixel.
- threshold  in  PIX_BITS  edge threshold, sampled in stage 3.
- binary_mode  in  1  1 = binary output, 0 = magnitude output; sampled in stage 3.
- out_pixel  out  WORD_SIZE  result, zero-extended.
- out_edge  out  1  1 when saturated magnitude >= threshold.
- out_AH  out  10  centre-pixel horizontal coordinate.
- out_AV  out  9  centre-pixel vertical coordinate.
- out_valid  out  1  outputs valid.

Behaviour:
- Reset: all outputs and all pipeline registers are 0, including every stage valid bit. Reset applies regardless of in_valid or pipeline state. The first valid output after reset deasserts requires a fresh in_valid. No stale data emerges.
- Pipeline: 3 stages, fixed latency of 3 clocks from in_valid to out_valid. No stalls, no backpressure. A bubble (in_valid=0) propagates as out_valid=0. Stage contents advance every clock.
- Centre coordinate:
  - ch = AH-1, cv = AV-1.
  - If AH=0, ch = ROW_SIZE-1. If AV=0, cv = COL_SIZE-1.
  - ch/cv are carried through the pipe, and out_AH/out_AV = ch/cv.
- Stage 1:
  - Register p[i] = window[i][PIX_BITS-1:0].
  - Compute Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6).
  - Compute Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2).
  - Gx and Gy are signed, PIX_BITS+3 bits, range ±4*(2^PIX_BITS-1); no overflow permitted.
  - Compute border = (ch==0) | (ch==ROW_SIZE-1) | (cv==0) | (cv==COL_SIZE-1).
- Stage 2: ax = |Gx|, ay = |Gy|, unsigned PIX_BITS+2 bits. The absolute value of the most negative reachable value is exact.
- Stage 3:
  - mag_raw = (ax+ay) >> SHIFT, computed at PIX_BITS+3 bits.
  - mag = min(mag_raw, 2^PIX_BITS-1).
  - edge = (mag >= threshold); equality counts as edge.
  - If border, then mag = 0 and edge = 0.
  - out_pixel = binary_mode ? (edge ? 2^PIX_BITS-1 : 0) : mag.
- When out_valid=0: out_pixel, out_edge, out_AH and out_AV hold 0. Bench checks them only when out_valid=1.
- Control timing: threshold and binary_mode changes take effect on the output 1 clock later. They are not pipelined with data.
- Coordinate wrap: coordinate wrap at line/frame end produces no special pipeline action beyond the border rule.

Test Plan:
- Flat field, all taps = 0x0040, AH=10, AV=10, in_valid=1 one cycle, threshold=1 -> 3 clocks later: out_valid=1, out_pixel=0, out_edge=0, out_AH=9, out_AV=9.
- Vertical step, left column 0 / middle and right columns 100, AH=20, AV=20, SHIFT=0 -> Gx=400, Gy=0, out_pixel=255 (saturated), out_edge=1 with threshold=200. With SHIFT=2 -> out_pixel=100.
- Negative horizontal step, top row 200 / other rows 0, threshold=255, binary_mode=1 -> Gy=-800, |Gy| saturates to 255, edge=1 (equality), out_pixel=0x00FF.
- Borders: same step stimulus with AH=1 (ch=0), with AH=0 (ch=ROW_SIZE-1=179), and with AV=1 (cv=0) -> out_valid=1, out_pixel=0, out_edge=0, out_AH=0/179/19 respectively.
- Throughput and bubbles: in_valid pattern 1,1,0,1 with distinct AH values 5,6,7,8 -> out_valid pattern 1,1,0,1 starting 3 clocks later, with out_AH 4,5,(0),7 in order.
- Reset mid-pipe: two valid inputs, reset high on the next clock for 1 cycle, then idle -> out_valid stays 0 for every cycle from reset onward; all outputs read 0.
